// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the RAM port arbiter slice.
package ram_port_arbiter_pkg;

   localparam int DEF_ADDR_WIDTH = 4;
   localparam int DEF_DATA_WIDTH = 8;

   // Access sequence phases; the encoding is fixed so it can be probed in the lab.
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETUP  = 2'b01,
      STROBE = 2'b10,
      HOLD   = 2'b11
   } state_t;

   // Grant identifiers, also the value reported on the owner output.
   localparam logic OWNER_A = 1'b0;
   localparam logic OWNER_B = 1'b1;

   // Two-way round-robin: a lone requester wins, a tie goes to whoever did not win last.
   // With no request the result is don't-care; the previous owner is returned.
   function automatic logic rr_pick(input logic [1:0] req, input logic last);
      logic pick;
      case (req)
         2'b01:   pick = OWNER_A;
         2'b10:   pick = OWNER_B;
         2'b11:   pick = ~last;
         default: pick = last;
      endcase
      return pick;
   endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side handshake bundle: both req/ack ports plus shared status.
interface ram_port_arbiter_if
   import ram_port_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

   logic                  a_req;
   logic                  a_wr;
   logic [ADDR_WIDTH-1:0] a_addr;
   logic [DATA_WIDTH-1:0] a_wdata;
   logic                  a_ack;

   logic                  b_req;
   logic                  b_wr;
   logic [ADDR_WIDTH-1:0] b_addr;
   logic [DATA_WIDTH-1:0] b_wdata;
   logic                  b_ack;

   logic [DATA_WIDTH-1:0] rdata;
   logic                  busy;
   logic                  owner;

   // Requester side (drives commands, observes completion).
   modport master (
      output a_req, a_wr, a_addr, a_wdata,
      output b_req, b_wr, b_addr, b_wdata,
      input  a_ack, b_ack, rdata, busy, owner
   );

   // Arbiter side.
   modport slave (
      input  a_req, a_wr, a_addr, a_wdata,
      input  b_req, b_wr, b_addr, b_wdata,
      output a_ack, b_ack, rdata, busy, owner
   );

endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick between requesters A (bit 0) and B (bit 1).
module rr_arb2
   import ram_port_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt
);

   // Pick the winner from the current requests and the previous grant.
   always_comb begin
      gnt = rr_pick(req, last);
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbiter and setup/strobe/hold sequencer sharing one asynchronous single-port RAM
// between two requesters. All RAM pins and acks are registered, decoded from the
// state being entered, so ram_we/ram_enable never glitch.
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   ram_port_arbiter_if.slave     bus,
   output logic                  ram_we,
   output logic                  ram_enable,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   inout  wire  [DATA_WIDTH-1:0] ram_data
);

   state_t                state_reg;
   logic                  owner_reg;
   logic                  busy_reg;
   logic                  a_ack_reg;
   logic                  b_ack_reg;
   logic [DATA_WIDTH-1:0] rdata_reg;
   logic                  ram_we_reg;
   logic                  ram_enable_reg;
   logic [ADDR_WIDTH-1:0] ram_addr_reg;
   logic                  drive_reg;
   logic                  wr_reg;
   logic [DATA_WIDTH-1:0] wdata_reg;

   logic [1:0]            req_vec;
   logic                  gnt;
   logic                  gnt_wr;
   logic [ADDR_WIDTH-1:0] gnt_addr;
   logic [DATA_WIDTH-1:0] gnt_wdata;

   assign req_vec = {bus.b_req, bus.a_req};

   rr_arb2 u_rr_arb2 (
      .req  (req_vec),
      .last (owner_reg),
      .gnt  (gnt)
   );

   // Steer the winning requester's command onto the latch inputs.
   always_comb begin
      if (gnt == OWNER_B) begin
         gnt_wr    = bus.b_wr;
         gnt_addr  = bus.b_addr;
         gnt_wdata = bus.b_wdata;
      end else begin
         gnt_wr    = bus.a_wr;
         gnt_addr  = bus.a_addr;
         gnt_wdata = bus.a_wdata;
      end
   end

   // Sequencer: advance the phase and load every output for the phase being entered.
   // ram_addr_reg doubles as the latched address; wr/wdata are latched at grant so
   // requester changes mid-transaction have no effect.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= IDLE;
         owner_reg      <= OWNER_B;
         busy_reg       <= 1'b0;
         a_ack_reg      <= 1'b0;
         b_ack_reg      <= 1'b0;
         rdata_reg      <= '0;
         ram_we_reg     <= 1'b0;
         ram_enable_reg <= 1'b0;
         ram_addr_reg   <= '0;
         drive_reg      <= 1'b0;
         wr_reg         <= 1'b0;
         wdata_reg      <= '0;
      end else begin
         a_ack_reg <= 1'b0;
         b_ack_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (|req_vec) begin
                  state_reg      <= SETUP;
                  owner_reg      <= gnt;
                  busy_reg       <= 1'b1;
                  wr_reg         <= gnt_wr;
                  wdata_reg      <= gnt_wdata;
                  ram_addr_reg   <= gnt_addr;
                  ram_we_reg     <= 1'b0;
                  ram_enable_reg <= ~gnt_wr;
                  drive_reg      <= gnt_wr;
               end
            end
            SETUP: begin
               state_reg      <= STROBE;
               ram_we_reg     <= wr_reg;
               ram_enable_reg <= ~wr_reg;
            end
            STROBE: begin
               state_reg      <= HOLD;
               ram_we_reg     <= 1'b0;
               ram_enable_reg <= 1'b0;
               if (!wr_reg) begin
                  rdata_reg <= ram_data;
               end
               a_ack_reg <= (owner_reg == OWNER_A);
               b_ack_reg <= (owner_reg == OWNER_B);
            end
            HOLD: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               drive_reg <= 1'b0;
            end
            default: begin
               state_reg      <= IDLE;
               busy_reg       <= 1'b0;
               drive_reg      <= 1'b0;
               ram_we_reg     <= 1'b0;
               ram_enable_reg <= 1'b0;
            end
         endcase
      end
   end

   // Data bus is driven only through a write's setup, strobe and hold phases.
   assign ram_data   = drive_reg ? wdata_reg : {DATA_WIDTH{1'bz}};

   assign ram_we     = ram_we_reg;
   assign ram_enable = ram_enable_reg;
   assign ram_addr   = ram_addr_reg;

   assign bus.a_ack  = a_ack_reg;
   assign bus.b_ack  = b_ack_reg;
   assign bus.rdata  = rdata_reg;
   assign bus.busy   = busy_reg;
   assign bus.owner  = owner_reg;

endmodule
